// File: rtl/load_use_fwd_unit.sv
// Load-use forwarding buffer: tracks in-flight loads in issue order and supplies
// returned load data to ID operands, stalling when a needed load is still outstanding.
module load_use_fwd_unit #(
  parameter int XLEN  = 32,
  parameter int REGW  = 5,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ld_issue,
  input  logic [REGW-1:0]              ld_rd,
  input  logic                         ld_data_vld,
  input  logic [XLEN-1:0]              ld_data,
  input  logic                         wb_retire,
  input  logic [REGW-1:0]              rs1,
  input  logic [REGW-1:0]              rs2,
  input  logic [XLEN-1:0]              fw0,
  input  logic [XLEN-1:0]              fw1,
  output logic [XLEN-1:0]              op0,
  output logic [XLEN-1:0]              op1,
  output logic                         hit0,
  output logic                         hit1,
  output logic                         stall,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic            valid_q [DEPTH];
  logic            ready_q [DEPTH];
  logic [REGW-1:0] rd_q    [DEPTH];
  logic [XLEN-1:0] data_q  [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            err_q;

  logic            dw_found;
  logic [PW-1:0]   dw_idx;
  logic            do_write;
  logic            do_pop;
  logic            do_push;
  logic            err_now;
  logic [XLEN-1:0] op_c  [2];
  logic            hit_c [2];
  logic            stall_c;

  // Slot holding the entry that is 'off' positions younger than the oldest one.
  function automatic logic [PW-1:0] age_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Returned data belongs to the oldest entry still waiting; the pop may consume
  // that same write in the cycle it arrives.
  always_comb begin
    dw_found = 1'b0;
    dw_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!dw_found && valid_q[age_idx(rd_ptr, i)] && !ready_q[age_idx(rd_ptr, i)]) begin
        dw_found = 1'b1;
        dw_idx   = age_idx(rd_ptr, i);
      end
    end
    do_write = ld_data_vld && dw_found;
    do_pop   = wb_retire && valid_q[rd_ptr] &&
               (ready_q[rd_ptr] || (do_write && (dw_idx == rd_ptr)));
    do_push  = ld_issue && (ld_rd != '0) && ((count_q != CW'(DEPTH)) || do_pop);
    err_now  = (ld_data_vld && !dw_found) || (wb_retire && !do_pop) ||
               (ld_issue && (ld_rd != '0) && !do_push);
  end

  // Operand lookup walks oldest to youngest so the last match is the youngest.
  always_comb begin
    logic [REGW-1:0] rs_k;
    logic            sel_found;
    logic [PW-1:0]   sel_idx;
    stall_c = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rs_k      = (k == 0) ? rs1 : rs2;
      op_c[k]   = (k == 0) ? fw0 : fw1;
      hit_c[k]  = 1'b0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if ((rs_k != '0) && valid_q[age_idx(rd_ptr, i)] && (rd_q[age_idx(rd_ptr, i)] == rs_k)) begin
          sel_found = 1'b1;
          sel_idx   = age_idx(rd_ptr, i);
        end
      end
      if (sel_found) begin
        if (ready_q[sel_idx]) begin
          op_c[k]  = data_q[sel_idx];
          hit_c[k] = 1'b1;
        end else if (do_write && (dw_idx == sel_idx)) begin
          op_c[k]  = ld_data;
          hit_c[k] = 1'b1;
        end else begin
          stall_c = 1'b1;
        end
      end
    end
  end

  // Write, then pop, then push: a full-buffer push+pop reuses the popped slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ready_q[i] <= 1'b0;
        rd_q[i]    <= '0;
        data_q[i]  <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (do_write) begin
        data_q[dw_idx]  <= ld_data;
        ready_q[dw_idx] <= 1'b1;
      end
      if (do_pop) begin
        valid_q[rd_ptr] <= 1'b0;
        ready_q[rd_ptr] <= 1'b0;
        rd_ptr          <= wrap_inc(rd_ptr);
      end
      if (do_push) begin
        valid_q[wr_ptr] <= 1'b1;
        ready_q[wr_ptr] <= 1'b0;
        rd_q[wr_ptr]    <= ld_rd;
        wr_ptr          <= wrap_inc(wr_ptr);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
      err_q   <= err_q | err_now;
    end
  end

  assign op0   = op_c[0];
  assign op1   = op_c[1];
  assign hit0  = hit_c[0];
  assign hit1  = hit_c[1];
  assign stall = stall_c;
  assign count = count_q;
  assign err   = err_q;

endmodule

// File: tb/tb_load_use_fwd_unit.sv
// Directed bench for load_use_fwd_unit: a queue-based model of in-flight loads
// predicts every output each cycle; literal checks pin the model on key cases.
module tb_load_use_fwd_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_rd = '0;
  logic        ld_data_vld = 1'b0;
  logic [31:0] ld_data = '0;
  logic        wb_retire = 1'b0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] fw0 = '0;
  logic [31:0] fw1 = '0;
  logic [31:0] op0, op1;
  logic        hit0, hit1, stall, err;
  logic [1:0]  count;

  typedef struct {
    logic [4:0]  rd;
    bit          ready;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  bit   err_m = 0;
  int   vectors = 0;
  int   miscompares = 0;

  load_use_fwd_unit #(.XLEN(32), .REGW(5), .DEPTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .ld_issue(ld_issue), .ld_rd(ld_rd),
    .ld_data_vld(ld_data_vld), .ld_data(ld_data), .wb_retire(wb_retire),
    .rs1(rs1), .rs2(rs2), .fw0(fw0), .fw1(fw1), .op0(op0), .op1(op1),
    .hit0(hit0), .hit1(hit1), .stall(stall), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // What an operand must resolve to, given the loads still in flight.
  task automatic expectOperand(input logic [4:0] rs, input logic [31:0] fw,
                               output logic [31:0] op, output logic hit, output logic st);
    int youngest = -1;
    int pending  = -1;
    op = fw; hit = 1'b0; st = 1'b0;
    if (rs != 0)
      foreach (q[k]) if (q[k].rd == rs) youngest = k;
    foreach (q[k]) if (!q[k].ready && pending < 0) pending = k;
    if (youngest >= 0) begin
      if (q[youngest].ready) begin
        op = q[youngest].data; hit = 1'b1;
      end else if (ld_data_vld && youngest == pending) begin
        op = ld_data; hit = 1'b1;
      end else begin
        st = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    logic [31:0] e_op0, e_op1;
    logic        e_h0, e_h1, e_s0, e_s1;
    expectOperand(rs1, fw0, e_op0, e_h0, e_s0);
    expectOperand(rs2, fw1, e_op1, e_h1, e_s1);
    pin("op0", op0, e_op0);
    pin("op1", op1, e_op1);
    pin("hit0", {31'b0, hit0}, {31'b0, e_h0});
    pin("hit1", {31'b0, hit1}, {31'b0, e_h1});
    pin("stall", {31'b0, stall}, {31'b0, e_s0 | e_s1});
    pin("count", {30'b0, count}, q.size());
    pin("err", {31'b0, err}, {31'b0, err_m});
  endtask

  task automatic modelUpdate();
    int pending = -1;
    foreach (q[k]) if (!q[k].ready && pending < 0) pending = k;
    if (ld_data_vld) begin
      if (pending >= 0) begin
        q[pending].ready = 1;
        q[pending].data  = ld_data;
      end else err_m = 1;
    end
    if (wb_retire) begin
      if (q.size() > 0 && q[0].ready) void'(q.pop_front());
      else err_m = 1;
    end
    if (ld_issue && ld_rd != 0) begin
      if (q.size() < 3) q.push_back('{rd: ld_rd, ready: 0, data: '0});
      else err_m = 1;
    end
  endtask

  task automatic applyStimulus(input bit iss, input logic [4:0] rd, input bit dv,
                               input logic [31:0] d, input bit ret,
                               input logic [4:0] s1, input logic [4:0] s2);
    @(negedge clk);
    ld_issue = iss; ld_rd = rd; ld_data_vld = dv; ld_data = d; wb_retire = ret;
    rs1 = s1; rs2 = s2; fw0 = $urandom; fw1 = $urandom;
    #1;
    checkOutput();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) modelUpdate();
    #1;
  endtask

  task automatic cyc(input bit iss, input logic [4:0] rd, input bit dv,
                     input logic [31:0] d, input bit ret,
                     input logic [4:0] s1, input logic [4:0] s2);
    applyStimulus(iss, rd, dv, d, ret, s1, s2);
    tick();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    ld_issue = 0; ld_data_vld = 0; wb_retire = 0; ld_rd = 0;
    q.delete(); err_m = 0;
    #3;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    $display("[TB] start");
    // Reset state with a live lookup request.
    rs1 = 5; rs2 = 7; fw0 = 32'h100; fw1 = 32'h200;
    #2;
    pin("reset op0", op0, 32'h100);
    pin("reset stall", {31'b0, stall}, 32'd0);
    doReset();

    // Single load then consumer: stall, then same-cycle bypass.
    cyc(1, 5, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 5, 0);
    pin("x5 stall", {31'b0, stall}, 32'd1);
    pin("x5 op0 passthru", op0, fw0);
    tick();
    applyStimulus(0, 0, 1, 32'hDEADBEEF, 0, 5, 0);
    pin("x5 bypass op0", op0, 32'hDEADBEEF);
    pin("x5 bypass hit0", {31'b0, hit0}, 32'd1);
    pin("x5 bypass stall", {31'b0, stall}, 32'd0);
    tick();
    cyc(0, 0, 0, 0, 1, 5, 5);
    cyc(0, 0, 0, 0, 0, 5, 5);

    // Same destination twice: youngest wins.
    cyc(1, 7, 0, 0, 0, 7, 7);
    cyc(1, 7, 1, 32'h11, 0, 7, 7);
    cyc(0, 0, 1, 32'h22, 0, 7, 7);
    applyStimulus(0, 0, 0, 0, 0, 3, 7);
    pin("youngest op1", op1, 32'h22);
    pin("youngest hit1", {31'b0, hit1}, 32'd1);
    tick();
    cyc(0, 0, 0, 0, 1, 7, 7);
    cyc(0, 0, 0, 0, 1, 7, 7);

    // x0 never tracked or matched.
    cyc(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    pin("x0 count", {30'b0, count}, 32'd0);
    pin("x0 op0", op0, fw0);
    tick();

    // Steady push+data+pop on one entry walks both pointers around the ring.
    cyc(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      cyc(1, 5'((i + 1) % 3 + 1), 1, 32'hA0 + i, 1, 5'(i % 3 + 1), 5'((i + 1) % 3 + 1));
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    pin("ring err", {31'b0, err}, 32'd0);
    pin("ring count", {30'b0, count}, 32'd1);
    tick();

    // Full buffer: issue with retire is accepted, without retire is an error.
    doReset();
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 2, 1, 32'hA1, 0, 1, 2);
    cyc(1, 3, 1, 32'hA2, 0, 1, 3);
    cyc(0, 0, 1, 32'hA3, 0, 2, 3);
    cyc(1, 4, 0, 0, 1, 1, 3);
    applyStimulus(0, 0, 0, 0, 0, 4, 1);
    pin("full+retire count", {30'b0, count}, 32'd3);
    pin("full+retire err", {31'b0, err}, 32'd0);
    tick();
    cyc(1, 6, 0, 0, 0, 4, 3);
    applyStimulus(0, 0, 0, 0, 0, 6, 2);
    pin("full drop count", {30'b0, count}, 32'd3);
    pin("full drop err", {31'b0, err}, 32'd1);
    tick();

    // Mid-cycle asynchronous reset with entries pending.
    doReset();
    cyc(1, 9, 0, 0, 0, 0, 0);
    cyc(1, 10, 0, 0, 0, 9, 10);
    applyStimulus(0, 0, 0, 0, 0, 9, 10);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete(); err_m = 0;
    #1;
    pin("async count", {30'b0, count}, 32'd0);
    pin("async stall", {31'b0, stall}, 32'd0);
    pin("async hit0", {31'b0, hit0}, 32'd0);
    pin("async op1", op1, fw1);
    checkOutput();
    doReset();

    // Protocol errors on an empty buffer.
    cyc(0, 0, 0, 0, 1, 4, 6);
    applyStimulus(0, 0, 0, 0, 0, 4, 6);
    pin("empty retire err", {31'b0, err}, 32'd1);
    tick();
    doReset();
    cyc(0, 0, 1, 32'h55, 0, 2, 3);
    applyStimulus(0, 0, 0, 0, 0, 2, 3);
    pin("orphan data err", {31'b0, err}, 32'd1);
    pin("orphan data op0", op0, fw0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
